// File: rtl/shake_squeezer.sv
// Sponge squeeze stage: streams the 1088-bit rate as 64-bit words, then asks the core for another block.
// First word 2 edges after start when state is ready; dout held under backpressure; lanes byte-reversed if SQZ_BYTESWAP_EN.
module shake_squeezer #(
  parameter int RATE_WORDS = 17,
  parameter int LEN_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] out_len_words,
  input  logic [1599:0]    perm_out,
  input  logic             perm_out_ready,
  input  logic             perm_ack,
  output logic             perm_squeeze,
  output logic [63:0]      dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             done
);

  localparam int RATE_BITS = RATE_WORDS * 64;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_EMIT,
    S_REQ
  } state_t;

  state_t                 state, state_n;
  logic [RATE_BITS-1:0]   buffer;
  logic [4:0]             word_idx;
  logic [LEN_W-1:0]       remaining;
  logic                   done_q, done_n;
  logic                   xfer;
  logic                   last_word;
  logic                   block_end;

  // Capacity lanes never leave the core.
  logic unused_capacity;
  assign unused_capacity = ^perm_out[1599-RATE_BITS:0];

  function automatic logic [63:0] lane_out(input logic [63:0] lane);
    logic [63:0] r;
`ifdef SQZ_BYTESWAP_EN
    for (int i = 0; i < 8; i++) begin
      r[8*i +: 8] = lane[56-8*i +: 8];
    end
`else
    r = lane;
`endif
    return r;
  endfunction

  assign dout_valid   = (state == S_EMIT);
  assign perm_squeeze = (state == S_REQ);
  assign busy         = (state != S_IDLE);
  assign done         = done_q;
  assign dout         = lane_out(buffer[RATE_BITS-1 -: 64]);

  assign xfer      = dout_valid & dout_ready;
  assign last_word = (remaining == LEN_W'(1));
  assign block_end = (word_idx == 5'(RATE_WORDS - 1));

  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (out_len_words == '0) begin
            done_n = 1'b1;
          end else begin
            state_n = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (perm_out_ready) begin
          state_n = S_EMIT;
        end
      end
      S_EMIT: begin
        if (xfer) begin
          if (last_word) begin
            done_n  = 1'b1;
            state_n = S_IDLE;
          end else if (block_end) begin
            state_n = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (perm_ack) begin
          state_n = S_WAIT;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      done_q <= done_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buffer    <= '0;
      word_idx  <= '0;
      remaining <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && (out_len_words != '0)) begin
            remaining <= out_len_words;
          end
        end
        S_WAIT: begin
          if (perm_out_ready) begin
            buffer   <= perm_out[1599 -: RATE_BITS];
            word_idx <= '0;
          end
        end
        S_EMIT: begin
          // The FSM leaves EMIT on the last word, so remaining cannot underflow.
          if (xfer) begin
            buffer    <= {buffer[RATE_BITS-65:0], 64'd0};
            word_idx  <= word_idx + 5'd1;
            remaining <= remaining - LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  stall_hold_a: assert property (@(posedge clk) disable iff (reset)
    (dout_valid && !dout_ready) |=> (dout_valid && $stable(dout)));

endmodule

// File: tb/tb_shake_squeezer.sv
// Directed bench for shake_squeezer: short/long squeezes, backpressure, zero length, reset in REQ, lane byte order.
module tb_shake_squeezer;

  logic          clk;
  logic          reset;
  logic          start;
  logic [15:0]   out_len_words;
  logic [1599:0] perm_out;
  logic          perm_out_ready;
  logic          perm_ack;
  logic          perm_squeeze;
  logic [63:0]   dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;
  int sq_cycles;

  shake_squeezer #(.RATE_WORDS(17), .LEN_W(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .out_len_words  (out_len_words),
    .perm_out       (perm_out),
    .perm_out_ready (perm_out_ready),
    .perm_ack       (perm_ack),
    .perm_squeeze   (perm_squeeze),
    .dout           (dout),
    .dout_valid     (dout_valid),
    .dout_ready     (dout_ready),
    .busy           (busy),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
    if (perm_squeeze) sq_cycles++;
  endtask

  task automatic fill(input logic [63:0] base);
    perm_out = {1600{1'b1}};
    for (int k = 0; k < 17; k++) perm_out[1599-64*k -: 64] = base + 64'(k);
  endtask

  task automatic do_start(input logic [15:0] len);
    start = 1'b1;
    out_len_words = len;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [63:0] exp_word(input logic [63:0] w);
`ifdef SQZ_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24], w[39:32], w[47:40], w[55:48], w[63:56]};
`else
    return w;
`endif
  endfunction

  initial begin
    int xfers;
    int idx;
    int guard;
    logic seen_done;
    logic [2:0] pat;

    reset = 1'b1; start = 1'b0; out_len_words = '0; perm_out = '0;
    perm_out_ready = 1'b0; perm_ack = 1'b0; dout_ready = 1'b0;
    sq_cycles = 0;
    tick(); tick();
    chk("rst_valid", 64'(dout_valid), 64'd0);
    chk("rst_dout", dout, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_squeeze", 64'(perm_squeeze), 64'd0);
    reset = 1'b0;
    tick();

    // 1: three words from a ready state
    fill(64'h1000); perm_out_ready = 1'b1; dout_ready = 1'b1; sq_cycles = 0;
    do_start(16'd3);
    chk("t1_wait_valid", 64'(dout_valid), 64'd0);
    chk("t1_wait_busy", 64'(busy), 64'd1);
    tick();
    chk("t1_valid", 64'(dout_valid), 64'd1);
    chk("t1_w0", dout, exp_word(64'h1000));
    tick();
    chk("t1_w1", dout, exp_word(64'h1001));
    tick();
    chk("t1_w2", dout, exp_word(64'h1002));
    chk("t1_no_early_done", 64'(done), 64'd0);
    tick();
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_end_valid", 64'(dout_valid), 64'd0);
    chk("t1_end_busy", 64'(busy), 64'd0);
    tick();
    chk("t1_done_pulse", 64'(done), 64'd0);
    chk("t1_no_squeeze", 64'(sq_cycles), 64'd0);

    // 2: twenty words across two blocks
    do_start(16'd20);
    tick();
    for (int k = 0; k < 17; k++) begin
      chk($sformatf("t2_b0_w%0d", k), dout, exp_word(64'h1000 + 64'(k)));
      chk("t2_b0_valid", 64'(dout_valid), 64'd1);
      tick();
    end
    chk("t2_req_squeeze", 64'(perm_squeeze), 64'd1);
    chk("t2_req_valid", 64'(dout_valid), 64'd0);
    tick(); tick();
    chk("t2_hold_squeeze", 64'(perm_squeeze), 64'd1);
    perm_ack = 1'b1;
    tick();
    perm_ack = 1'b0; perm_out_ready = 1'b0;
    chk("t2_ack_squeeze", 64'(perm_squeeze), 64'd0);
    chk("t2_ack_valid", 64'(dout_valid), 64'd0);
    for (int c = 0; c < 5; c++) tick();
    chk("t2_refill_valid", 64'(dout_valid), 64'd0);
    chk("t2_refill_busy", 64'(busy), 64'd1);
    fill(64'h2000); perm_out_ready = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t2_b1_w%0d", k), dout, exp_word(64'h2000 + 64'(k)));
      tick();
    end
    chk("t2_done", 64'(done), 64'd1);
    chk("t2_end_busy", 64'(busy), 64'd0);

    // 3: five words under a 1,0,0 ready pattern
    fill(64'h3000);
    pat = 3'b001;
    do_start(16'd5);
    xfers = 0; idx = 0; seen_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      dout_ready = pat[c % 3];
      if (dout_valid) chk($sformatf("t3_c%0d", c), dout, exp_word(64'h3000 + 64'(idx)));
      if (dout_valid && dout_ready) begin
        xfers++;
        idx++;
      end
      tick();
      if (done) seen_done = 1'b1;
    end
    chk("t3_xfers", 64'(xfers), 64'd5);
    chk("t3_done_seen", 64'(seen_done), 64'd1);
    chk("t3_idle", 64'(busy), 64'd0);
    dout_ready = 1'b1;

    // 4: zero length
    sq_cycles = 0;
    do_start(16'd0);
    chk("t4_done", 64'(done), 64'd1);
    chk("t4_busy", 64'(busy), 64'd0);
    chk("t4_valid", 64'(dout_valid), 64'd0);
    tick();
    chk("t4_done_pulse", 64'(done), 64'd0);
    chk("t4_busy2", 64'(busy), 64'd0);
    chk("t4_no_squeeze", 64'(sq_cycles), 64'd0);

    // 5: reset while requesting a new block
    fill(64'h4000);
    do_start(16'd18);
    guard = 0;
    while (!perm_squeeze && guard < 100) begin
      tick();
      guard++;
    end
    chk("t5_reached_req", 64'(perm_squeeze), 64'd1);
    reset = 1'b1;
    tick();
    chk("t5_rst_squeeze", 64'(perm_squeeze), 64'd0);
    chk("t5_rst_valid", 64'(dout_valid), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_dout", dout, 64'd0);
    reset = 1'b0;
    tick();

    // 6: single word after reset, checks lane byte order
    fill(64'h0);
    perm_out[1599 -: 64] = 64'h0102030405060708;
    do_start(16'd1);
    tick();
    chk("t6_valid", 64'(dout_valid), 64'd1);
`ifdef SQZ_BYTESWAP_EN
    chk("t6_word", dout, 64'h0807060504030201);
`else
    chk("t6_word", dout, 64'h0102030405060708);
`endif
    tick();
    chk("t6_done", 64'(done), 64'd1);
    chk("t6_idle", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
